// File: rtl/irq_nest_pkg.sv
// Shared definitions for the nested interrupt controller: FSM state encoding,
// save-stack entry layout helper and vector table stride.
package irq_nest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_VECT    = 2'd2,
        ST_RESTORE = 2'd3
    } irq_state_e;

    // Each vector table entry is two words, so channel i lives at base + 2*i.
    localparam int VEC_STRIDE = 2;

    // Stack entries are packed as {id, ccr, pc}, pc in the least significant bits.
    function automatic int entry_w(input int id_w, input int flag_w, input int pc_w);
        return id_w + flag_w + pc_w;
    endfunction

endpackage

// File: rtl/irq_save_stack.sv
// LIFO of saved {id, ccr, pc} entries for nested interrupts.
// The top entry is presented combinationally so a pop can capture it in the same cycle.
module irq_save_stack
    import irq_nest_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     push_data_i,
    output logic [W-1:0]     top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Select the most recently pushed entry; zero when empty.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) top_o = mem_q[i];
        end
    end

    // Push writes the slot above the current top; pop just drops the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q == CNT_W'(i)) mem_q[i] <= push_data_i;
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/irq_nest_ctrl.sv
// Nested interrupt controller: edge-detected requests, fixed priority
// (lower index wins), core handshake, vector generation and a save stack
// of {pc, ccr, id} that is unwound on RTI.
//
// state   | meaning
// IDLE    | arbitrate pending channels, or execute an RTI pop
// REQ     | int_req asserted for the latched id, waiting for int_ack
// VECT    | one-cycle vec_valid pulse with the handler address
// RESTORE | one-cycle restore_valid pulse with the popped pc/ccr
module irq_nest_ctrl
    import irq_nest_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter int          PC_W       = 32,
    parameter int          FLAG_W     = 4,
    parameter int          NEST_DEPTH = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0,
    localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic               int_ack,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [FLAG_W-1:0]  ccr_in,
    input  logic               rti,
    output logic               int_req,
    output logic               vec_valid,
    output logic [PC_W-1:0]    vec_addr,
    output logic [ID_W-1:0]    int_id,
    output logic               restore_valid,
    output logic [PC_W-1:0]    restore_pc,
    output logic [FLAG_W-1:0]  restore_ccr,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_underflow
);

    localparam int ENTRY_W = entry_w(ID_W, FLAG_W, PC_W);

    irq_state_e         state_q;
    logic [NUM_IRQ-1:0] irq_prev_q, pend_q, pend_d, en_q;
    logic [ID_W-1:0]    id_q;
    logic               int_req_q, vec_valid_q, restore_valid_q, err_q, defer_q;
    logic [PC_W-1:0]    vec_addr_q, restore_pc_q;
    logic [FLAG_W-1:0]  restore_ccr_q;

    logic [ENTRY_W-1:0] stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full, stk_empty;
    logic [ID_W-1:0]    top_id, pri_id;
    logic [NUM_IRQ-1:0] elig, clr;
    logic               any_elig, id_elig;
    logic               rti_now, pop, underflow, accept;

    irq_save_stack #(
        .DEPTH (NEST_DEPTH),
        .W     (ENTRY_W)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .pop_i       (pop),
        .push_data_i ({id_q, ccr_in, pc_in}),
        .top_o       (stk_top),
        .count_o     (stk_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign top_id = stk_empty ? '0 : stk_top[PC_W+FLAG_W +: ID_W];

    // An RTI seen during VECT/RESTORE is replayed from IDLE via defer_q.
    assign rti_now   = ((state_q == ST_IDLE) && (rti || defer_q)) ||
                       ((state_q == ST_REQ) && rti);
    assign pop       = rti_now && !stk_empty;
    assign underflow = rti_now && stk_empty;
    assign accept    = (state_q == ST_REQ) && !rti && int_ack;

    // Eligibility and fixed-priority pick of the lowest eligible index.
    always_comb begin
        elig     = '0;
        clr      = '0;
        any_elig = 1'b0;
        id_elig  = 1'b0;
        pri_id   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            elig[i] = pend_q[i] && en_q[i] && !stk_full &&
                      (stk_empty || (ID_W'(i) < top_id));
            clr[i]  = accept && (id_q == ID_W'(i));
            if (elig[i]) begin
                any_elig = 1'b1;
                pri_id   = ID_W'(i);
            end
            if (id_q == ID_W'(i)) id_elig = elig[i];
        end
        // A fresh edge in the accept cycle is a new event and stays pending.
        pend_d = (pend_q & ~clr) | (irq_in & ~irq_prev_q);
    end

    // Edge detect, pending and enable registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
            en_q       <= '1;
        end else begin
            irq_prev_q <= irq_in;
            pend_q     <= pend_d;
            if (en_we) en_q <= en_wdata;
        end
    end

    // Control FSM with registered handshake and pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            id_q            <= '0;
            int_req_q       <= 1'b0;
            vec_valid_q     <= 1'b0;
            vec_addr_q      <= '0;
            restore_valid_q <= 1'b0;
            restore_pc_q    <= '0;
            restore_ccr_q   <= '0;
            err_q           <= 1'b0;
            defer_q         <= 1'b0;
        end else begin
            vec_valid_q     <= 1'b0;
            restore_valid_q <= 1'b0;
            if (underflow) err_q <= 1'b1;
            if (pop) begin
                restore_pc_q  <= stk_top[PC_W-1:0];
                restore_ccr_q <= stk_top[PC_W +: FLAG_W];
            end
            case (state_q)
                ST_IDLE: begin
                    defer_q <= rti && defer_q;
                    if (rti_now) begin
                        if (pop) begin
                            restore_valid_q <= 1'b1;
                            state_q         <= ST_RESTORE;
                        end
                    end else if (any_elig) begin
                        id_q      <= pri_id;
                        int_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rti) begin
                        if (pop) begin
                            int_req_q       <= 1'b0;
                            restore_valid_q <= 1'b1;
                            state_q         <= ST_RESTORE;
                        end
                    end else if (int_ack) begin
                        int_req_q   <= 1'b0;
                        vec_valid_q <= 1'b1;
                        vec_addr_q  <= PC_W'(VEC_BASE) + PC_W'(id_q) * PC_W'(VEC_STRIDE);
                        state_q     <= ST_VECT;
                    end else if (!id_elig) begin
                        int_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    defer_q <= rti;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign int_req       = int_req_q;
    assign vec_valid     = vec_valid_q;
    assign vec_addr      = vec_addr_q;
    assign int_id        = top_id;
    assign restore_valid = restore_valid_q;
    assign restore_pc    = restore_pc_q;
    assign restore_ccr   = restore_ccr_q;
    assign depth         = stk_depth;
    assign err_underflow = err_q;

endmodule

// File: doc/irq_nest_ctrl.md
# irq_nest_ctrl

Parametrised interrupt controller replacing the single `interrupt` pin and the one-entry saved-flags latch of the pipelined core. It edge-detects NUM_IRQ request lines, arbitrates by fixed priority, handshakes with the fetch stage at an instruction boundary, and produces a per-channel vector address. Nested interrupts use a LIFO of saved {PC, CCR, id} entries, and the LIFO is popped on RTI. Sits beside Fetch and the status register, and drives the fetch PC-select and CCR-restore paths.

## Interface
- NUM_IRQ, 4: number of request channels (1..16).
- PC_W, 32: PC width.
- FLAG_W, 4: CCR width.
- NEST_DEPTH, 4: save-stack entries (≥1).
- VEC_BASE, 32'h0: vector table base; each channel's entry is 2 words.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  request lines, synchronous to clk; a rising edge sets pending.
- en_we  in  1  write strobe for the enable register.
- en_wdata  in  NUM_IRQ  new enable value.
- int_ack  in  1  core is at an instruction boundary and accepts the request.
- pc_in  in  PC_W  return PC, sampled on accept.
- ccr_in  in  FLAG_W  current CCR, sampled on accept.
- rti  in  1  one-cycle pulse: return-from-interrupt executed.
- int_req  out  1  request to core.
- vec_valid  out  1  one-cycle pulse: redirect fetch to vec_addr.
- vec_addr  out  PC_W  handler address.
- int_id  out  log2(NUM_IRQ)  channel in service (top of stack).
- restore_valid  out  1  one-cycle pulse: load restore_pc and restore_ccr.
- restore_pc  out  PC_W  PC to restore.
- restore_ccr  out  FLAG_W  CCR to restore.
- depth  out  clog2(NEST_DEPTH+1)  number of occupied stack entries.
- err_underflow  out  1  sticky; set by an RTI while the stack is empty.

## Operation
- Pending register: set on a rising edge of irq_in[i]; cleared when channel i is accepted. An edge arriving on an already-pending bit is merged, not counted.
- Enable register: resets to all ones. A channel is eligible when it is pending, enabled, the stack is not full, and either depth==0 or its index is strictly below the in-service id (lower index = higher priority).
- States:
  - IDLE: if any channel is eligible, latch the lowest eligible id → REQ.
  - REQ: int_req=1.
    - int_ack → push {pc_in, ccr_in, id}, clear pending[id] → VECT.
    - Latched id no longer eligible (disabled or stack change) → IDLE.
  - VECT: vec_valid=1; vec_addr = VEC_BASE + (id<<1), truncated to PC_W (wrap modulo 2^PC_W). → IDLE.
  - RESTORE: restore_valid=1 with the popped entry. → IDLE.
- RTI in IDLE or REQ with depth>0: pop → RESTORE, int_req dropped. RTI takes precedence over a same-cycle int_ack, and that ack is ignored.
- RTI with depth==0: no pop, set err_underflow, state unchanged.
- RTI in VECT: the pop is deferred one cycle and executed in IDLE.
- int_id shows the top-of-stack id (0 when empty).

## Timing
- Reset values: all outputs 0; pending 0; enable all ones; stack empty; state IDLE.
- irq_in edge at cycle n → pending at n+1 → int_req at n+2 (when the channel is eligible).
- int_ack sampled high at edge k → vec_valid high for cycle k+1 only.
- rti at edge k → restore_valid high for cycle k+1 only; depth decrements at edge k.
- An en_we write takes effect at the next edge. An ack and a disabling write in the same cycle: the ack wins.
- Asserting reset mid-operation clears all state immediately; an in-flight VECT or RESTORE pulse is lost.

## Structure
- Shared header `irq_nest_pkg`: state encoding (IDLE, REQ, VECT, RESTORE), stack entry field layout {id, ccr, pc}, and vector stride constant 2.
- Sub-module `irq_save_stack`: NEST_DEPTH-entry LIFO with push/pop, full/empty, and combinational top output.
- Priority encoder and FSM live in the top module.

## Test plan
- Single IRQ: edge on irq_in[2], pc_in=0x100, ccr_in=4'b0101, ack at first int_req → vec_valid with vec_addr=0x4, depth=1. Then rti → restore_pc=0x100, restore_ccr=0101, depth=0.
- Nesting: irq 3 accepted, then irq 1 edge → second accept, int_id=1, depth=2. An irq 2 edge while 1 is in service → no int_req until rti.
- Stack full (NEST_DEPTH=2): channels 3,2 in service, irq 0 pending → int_req stays 0. After rti → irq 0 requested.
- Simultaneous: rti and int_ack in the same cycle with depth=1 → restore_valid, no vec_valid, and the request re-arbitrates afterwards.
- Disable during REQ: en_wdata clears the requested bit without ack → int_req falls the next cycle and pending is kept. Re-enable → request again.
- rti with empty stack → err_underflow=1 and stays set. Reset asserted mid-REQ → all outputs 0 and enable=all ones.
